// File: rtl/cmd_queue.sv
// Command queue between the ROM fetch sequencer and the execute stage.
// Optional overflow reporting (ovf, drop_cnt) is enabled by defining CMD_QUEUE_OVF_EN.
module cmd_queue #(
  parameter int DATA_W      = 14,
  parameter int ADDR_W      = 12,
  parameter int OPC_W       = 4,
  parameter int DEPTH       = 8,
  parameter int PTR_W       = 3,
  parameter int PAUSE_SLACK = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_write,
  input  logic [ADDR_W-1:0]       addr_in,
  input  logic [DATA_W-1:0]       rom_data,
  input  logic                    flush,
  output logic                    pause_read,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OPC_W-1:0]        out_opcode,
  output logic [DATA_W-OPC_W-1:0] out_operand,
  output logic [ADDR_W-1:0]       out_addr,
  output logic [PTR_W:0]          level
`ifdef CMD_QUEUE_OVF_EN
  ,
  output logic                    ovf,
  output logic [7:0]              drop_cnt
`endif
);

  localparam int ENT_W = DATA_W + ADDR_W;
  localparam logic [PTR_W:0]   C_FULL     = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W+1:0] C_PAUSE_TH = (PTR_W+2)'(DEPTH - PAUSE_SLACK);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return p + {{(PTR_W-1){1'b0}}, 1'b1};
  endfunction

  logic [ENT_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_level;
  logic              r_cap_valid;
  logic [ADDR_W-1:0] r_cap_addr;

  logic              w_full;
  logic              w_valid;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [PTR_W+1:0]  w_occ;
  logic [ENT_W-1:0]  w_head;

  // Handshake decode; flush cancels both a pop and the pending capture push.
  always_comb begin
    w_full  = (r_level == C_FULL);
    w_valid = (r_level != {(PTR_W+1){1'b0}});
    w_pop   = 1'b0;
    w_push  = 1'b0;
    w_drop  = 1'b0;
    if (flush) begin
      w_pop  = 1'b0;
      w_push = 1'b0;
      w_drop = 1'b0;
    end else begin
      w_pop  = w_valid & out_ready;
      w_push = r_cap_valid & (~w_full | w_pop);
      w_drop = r_cap_valid & w_full & ~w_pop;
    end
  end

  // Capture stage: remembers the fetch address until its ROM data returns.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cap_valid <= 1'b0;
      r_cap_addr  <= {ADDR_W{1'b0}};
    end else if (flush) begin
      r_cap_valid <= 1'b0;
    end else begin
      r_cap_valid <= cmd_write;
      if (cmd_write) begin
        r_cap_addr <= addr_in;
      end
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_level  <= {(PTR_W+1){1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + {{PTR_W{1'b0}}, 1'b1};
        2'b01:   r_level <= r_level - {{PTR_W{1'b0}}, 1'b1};
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_mem[r_wr_ptr] <= {rom_data, r_cap_addr};
    end
  end

`ifdef CMD_QUEUE_OVF_EN
  logic       r_ovf;
  logic [7:0] r_drop_cnt;

  // Sticky overflow flag and saturating drop counter; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (r_drop_cnt != 8'hFF) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  assign ovf      = r_ovf;
  assign drop_cnt = r_drop_cnt;
`endif

  // Counting the capture slot keeps room for fetches already issued.
  assign w_occ       = {1'b0, r_level} + {{(PTR_W+1){1'b0}}, r_cap_valid};
  assign pause_read  = (w_occ >= C_PAUSE_TH);

  assign w_head      = r_mem[r_rd_ptr];
  assign out_valid   = w_valid;
  assign out_opcode  = w_head[ENT_W-1 -: OPC_W];
  assign out_operand = w_head[ADDR_W +: (DATA_W-OPC_W)];
  assign out_addr    = w_head[ADDR_W-1:0];
  assign level       = r_level;

endmodule

// File: tb/tb_cmd_queue.sv
// Directed bench for cmd_queue: the bench plays the ROM and keeps a scoreboard
// of accepted commands that is checked against every pop.
module tb_cmd_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_write;
  logic [11:0] addr_in;
  logic [13:0] rom_data;
  logic        flush;
  logic        pause_read;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_opcode;
  logic [9:0]  out_operand;
  logic [11:0] out_addr;
  logic [3:0]  level;
`ifdef CMD_QUEUE_OVF_EN
  logic        ovf;
  logic [7:0]  drop_cnt;
`endif

  cmd_queue dut (
    .clk(clk), .reset(reset), .cmd_write(cmd_write), .addr_in(addr_in),
    .rom_data(rom_data), .flush(flush), .pause_read(pause_read),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_operand(out_operand), .out_addr(out_addr), .level(level)
`ifdef CMD_QUEUE_OVF_EN
    , .ovf(ovf), .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [25:0] sb[$];
  logic        m_cap = 1'b0;
  logic [11:0] m_cap_addr = 12'd0;
  int          m_drops = 0;
  logic        chk_en = 1'b0;
  logic [11:0] last_pop = 12'd0;
  int          n_pops = 0;
  int          max_level = 0;
  int          pops_before;

  function automatic logic [13:0] rom(input logic [11:0] a);
    if (a == 12'h005) return 14'h2A7F;
    else              return {a[3:0], a[9:0]} ^ 14'h2D31;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive ROM data, check outputs mid-cycle, advance the model.
  task automatic cycle();
    logic [25:0] e;
    logic        pop_m;
    rom_data = m_cap ? rom(m_cap_addr) : 14'($urandom);
    @(negedge clk);
    if (chk_en) begin
      chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      chk("level", 32'(level), 32'(sb.size()));
      chk("pause_read", 32'(pause_read), 32'((sb.size() + int'(m_cap)) >= 5));
`ifdef CMD_QUEUE_OVF_EN
      chk("ovf", 32'(ovf), 32'(m_drops != 0));
      chk("drop_cnt", 32'(drop_cnt), 32'((m_drops > 255) ? 255 : m_drops));
`endif
      if (int'(level) > max_level) max_level = int'(level);
    end
    pop_m = (sb.size() != 0) && out_ready && !flush && !reset;
    if (pop_m) begin
      e = sb.pop_front();
      chk("head_opcode", 32'(out_opcode), 32'(e[25:22]));
      chk("head_operand", 32'(out_operand), 32'(e[21:12]));
      chk("head_addr", 32'(out_addr), 32'(e[11:0]));
      last_pop = e[11:0];
      n_pops++;
    end
    if (reset) begin
      sb.delete();
      m_cap = 1'b0;
      m_drops = 0;
    end else if (flush) begin
      sb.delete();
      m_cap = 1'b0;
    end else begin
      if (m_cap) begin
        if (sb.size() < 8) sb.push_back({rom_data, m_cap_addr});
        else m_drops++;
      end
      m_cap = cmd_write;
      m_cap_addr = addr_in;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; cmd_write = 1'b0; addr_in = 12'd0; rom_data = 14'd0;
    flush = 1'b0; out_ready = 1'b0;
    cycle(); cycle();
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_pause", 32'(pause_read), 32'd0);

    // Single fetch: visible two edges after cmd_write.
    cmd_write = 1'b1; addr_in = 12'h005; cycle();
    cmd_write = 1'b0; cycle();
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_opcode", 32'(out_opcode), 32'hA);
    chk("single_operand", 32'(out_operand), 32'h27F);
    chk("single_addr", 32'(out_addr), 32'h005);
    chk("single_level", 32'(level), 32'd1);
    out_ready = 1'b1; cycle();
    out_ready = 1'b0;

    // Fill without consuming; the ninth push is dropped.
    for (int i = 0; i < 9; i++) begin
      cmd_write = 1'b1; addr_in = 12'(i); cycle();
    end
    cmd_write = 1'b0; cycle();
    chk("fill_level", 32'(level), 32'd8);
    chk("fill_pause", 32'(pause_read), 32'd1);
`ifdef CMD_QUEUE_OVF_EN
    chk("fill_ovf", 32'(ovf), 32'd1);
    chk("fill_drop_cnt", 32'(drop_cnt), 32'd1);
`endif

    // Full with simultaneous push and pop.
    cmd_write = 1'b1; addr_in = 12'h009; cycle();
    cmd_write = 1'b0; out_ready = 1'b1; cycle();
    chk("fullpp_level", 32'(level), 32'd8);
    chk("fullpp_popped", 32'(last_pop), 32'h000);
    for (int i = 0; i < 8; i++) cycle();
    chk("fullpp_last", 32'(last_pop), 32'h009);
    chk("drain_level", 32'(level), 32'd0);

    // Streaming with continuous consumption across pointer wrap.
    max_level = 0;
    pops_before = n_pops;
    for (int i = 0; i < 20; i++) begin
      cmd_write = 1'b1; addr_in = 12'h100 + 12'(i); cycle();
    end
    cmd_write = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    chk("wrap_pops", 32'(n_pops - pops_before), 32'd20);
    chk("wrap_last", 32'(last_pop), 32'h113);
    chk("wrap_max_le2", 32'(max_level <= 2), 32'd1);
    out_ready = 1'b0;

    // Flush with four buffered entries and one in capture.
    for (int i = 0; i < 5; i++) begin
      cmd_write = 1'b1; addr_in = 12'h200 + 12'(i); cycle();
    end
    chk("preflush_level", 32'(level), 32'd4);
    flush = 1'b1; cmd_write = 1'b1; addr_in = 12'h2FF; cycle();
    flush = 1'b0; cmd_write = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_pause", 32'(pause_read), 32'd0);
    for (int i = 0; i < 3; i++) cycle();
    chk("flush_nostale", 32'(level), 32'd0);
    cmd_write = 1'b1; addr_in = 12'h3AB; cycle();
    cmd_write = 1'b0; cycle();
    chk("postflush_valid", 32'(out_valid), 32'd1);
    chk("postflush_addr", 32'(out_addr), 32'h3AB);
    out_ready = 1'b1; cycle();
    out_ready = 1'b0;

    // Reset mid-stream at level 6.
    for (int i = 0; i < 6; i++) begin
      cmd_write = 1'b1; addr_in = 12'h300 + 12'(i); cycle();
    end
    cmd_write = 1'b0; cycle();
    chk("prerst_level", 32'(level), 32'd6);
    reset = 1'b1; cmd_write = 1'b1; addr_in = 12'h3FF; cycle();
    reset = 1'b0; cmd_write = 1'b0;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_pause", 32'(pause_read), 32'd0);
`ifdef CMD_QUEUE_OVF_EN
    chk("midrst_ovf", 32'(ovf), 32'd0);
    chk("midrst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    cycle();
    chk("postrst_level", 32'(level), 32'd0);
    cmd_write = 1'b1; addr_in = 12'h0AA; cycle();
    cmd_write = 1'b0; cycle();
    chk("postrst_addr", 32'(out_addr), 32'h0AA);
    out_ready = 1'b1; cycle(); cycle();
    out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cmd_queue.md
Name: cmd_queue

Overview:
Instruction buffer directly downstream of the ROM fetch sequencer. It captures each command word the ROM returns, along with the fetch address that produced it, in a small FIFO. It presents buffered commands to the execute stage as opcode/operand fields under a valid/ready handshake. It drives pause_read back to the fetcher so that in-flight fetches never overflow the queue.

Parameters:
DATA_W, 14, command word width
ADDR_W, 12, ROM address width
OPC_W, 4, opcode width; opcode = rom_data[DATA_W-1 -: OPC_W], operand = rom_data[DATA_W-OPC_W-1:0]
DEPTH, 8, FIFO entries; power of two, at least 4
PTR_W, 3, log2(DEPTH)
PAUSE_SLACK, 3, free entries reserved for fetches already in flight when pause asserts

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
cmd_write  in  1  fetcher strobe: a ROM read for addr_in was issued this cycle
addr_in  in  ADDR_W  fetch address accompanying cmd_write
rom_data  in  DATA_W  ROM read data, valid exactly one cycle after the cmd_write cycle
flush  in  1  discard all buffered and in-flight commands (branch taken)
pause_read  out  1  stall request to fetcher
out_valid  out  1  head entry available
out_ready  in  1  execute stage consumes head this cycle when out_valid=1
out_opcode  out  OPC_W  opcode of head entry
out_operand  out  DATA_W-OPC_W  operand of head entry
out_addr  out  ADDR_W  fetch address of head entry
level  out  PTR_W+1  number of valid FIFO entries, 0..DEPTH

Behaviour:
- Reset: wr_ptr, rd_ptr, level, cap_valid, cap_addr = 0; out_valid=0; pause_read=0. FIFO contents are don't-care. Reset has priority over flush and over all other inputs.
- Capture stage: at the edge where cmd_write=1, register cap_valid<=1 and cap_addr<=addr_in; otherwise cap_valid<=0.
- In the following cycle, cap_valid=1 means {rom_data, cap_addr} is pushed at the next edge. Latency from the cmd_write cycle to out_valid=1 with an empty queue is 2 edges.
- Back-to-back cmd_write is supported: one push per cycle.
- Pop: occurs when out_valid && out_ready. rd_ptr advances by 1 modulo DEPTH.
- Push: writes mem[wr_ptr]. wr_ptr advances by 1 modulo DEPTH. Both pointers wrap naturally at PTR_W bits.
- level: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop or on neither.
- Full (level==DEPTH) with push and no pop: the push is dropped. State is unchanged apart from the overflow feature below.
- Full with push and pop in the same cycle: both succeed and level stays at DEPTH.
- Empty (level==0): out_valid=0 and out_ready is ignored. A push into an empty queue is visible at the head on the next cycle; there is no same-cycle bypass.
- Output fields are a combinational read of mem[rd_ptr] and are don't-care while out_valid=0.
- pause_read: combinational from registers, equal to (level + cap_valid) >= DEPTH - PAUSE_SLACK. With the defaults it asserts at effective occupancy 5.
- flush: at the edge, wr_ptr=rd_ptr=0, level=0, cap_valid=0. A cmd_write in the same cycle is discarded. A pop in the same cycle is treated as not occurring and the head is lost. After the edge, out_valid=0 and pause_read=0. rom_data in the cycle after flush is ignored.
- Reset or flush mid-burst: the next accepted command is the first cmd_write seen at or after the first cycle following the reset/flush edge.

Optional Feature:
CMD_QUEUE_OVF_EN
- When defined: adds output ovf (1 bit, sticky) and drop_cnt (8 bits, saturating at 255).
- A push dropped because the queue is full sets ovf=1 and increments drop_cnt.
- Both are cleared by reset only; flush does not clear them.
- When undefined: the ports do not exist and drops are silent.

Test Plan:
- Single fetch: reset, then cmd_write=1 with addr_in=0x005; next cycle rom_data=0x2A7F. Expect out_valid=1 two edges after cmd_write, out_opcode=0xA, out_operand=0x27F, out_addr=0x005, level=1.
- Fill with out_ready=0: 8 back-to-back fetches at addresses 0..7. Expect pause_read=1 once level+cap_valid reaches 5, and level=8 after the final push. A 9th push is dropped, level stays 8, and ovf=1 with drop_cnt=1 when the feature is enabled.
- Full with simultaneous push/pop: in the cycle a push arrives, out_ready=1. Expect level to stay 8, the popped entry to be address 0, and the new entry to be retained and read out last.
- Wrap-around: stream 20 commands with out_ready=1 continuously. Expect in-order output of addresses 0..19 with data intact, pointers wrapping twice, and level never exceeding 2.
- Flush: with level=4 and cap_valid=1, assert flush together with cmd_write. Expect out_valid=0, level=0 and pause_read=0 next cycle, and no stale entry later. The first fetch after flush appears at the head with its own address.
- Reset mid-stream: assert reset while level=6. Expect all outputs at reset values the next cycle, while ovf/drop_cnt, if enabled, read 0.
